// File: rtl/reg_dump_reader_pkg.sv
// Shared widths and FSM encodings for the register-file dump reader.
package reg_dump_reader_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/reg_file.sv
// Register file: one synchronous write port, one combinational read port. Register 0 reads 0.
// Latency: write visible the cycle after the write edge. No backpressure.
module reg_file #(
  parameter int DATA_WIDTH = reg_dump_reader_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = reg_dump_reader_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata = (raddr == '0) ? '0 : regs[raddr];

endmodule

// File: rtl/reg_dump_reader.sv
// Streams an inclusive, wrapping register range as (addr, data) words over valid/ready.
// Latency: first word valid 1 cycle after start is accepted, then one word per 2 cycles.
// Backpressure: out_* held stable while out_ready is low.
module reg_dump_reader #(
  parameter int DATA_WIDTH = reg_dump_reader_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = reg_dump_reader_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] first_addr,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done
);

  import reg_dump_reader_pkg::*;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] last;

  assign raddr = cur_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      last      <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      // abort drops the dump but leaves the last word visible on out_addr/out_data
      if (abort && (state != IDLE)) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              cur_addr <= first_addr;
              last     <= last_addr;
              busy     <= 1'b1;
              state    <= READ;
            end
          end
          READ: begin
            out_data  <= rdata;
            out_addr  <= cur_addr;
            out_valid <= 1'b1;
            state     <= SEND;
          end
          SEND: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              if (cur_addr == last) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                cur_addr <= cur_addr + ADDR_WIDTH'(1);
                state    <= READ;
              end
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
